ciclo_lavadora: RTL and testbench
=================================

CICLO_LAVADORA -- requirements
Module: ciclo_lavadora

Interface
REQ-001 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SECADO  input  1  drying command; pattern is two 1-cycle pulses: high, low, high, low.
- LAVADO  input  1  normal-wash command; same two-pulse pattern.
- LAVADO_PESADO  input  1  heavy-wash command; same two-pulse pattern.
- INSUFICIENTE  input  1  insufficient-payment indication; single 1-cycle pulse.
- PUERTA_ABIERTA  input  1  door-open sensor, level.
- VALVULA_AGUA  output  1  water inlet valve.
- MOTOR  output  1  drum motor, slow.
- MOTOR_RAPIDO  output  1  drum motor, spin.
- RESISTENCIA  output  1  dryer heater.
- OCUPADO  output  1  cycle in progress.
- FIN_CICLO  output  1  1-cycle pulse at cycle completion.
- ERROR_PAGO  output  1  sticky payment-error flag.

REQ-002 SHALL have the following parameters, one per line as name, default, meaning:
- T_LLENADO  8  fill duration, in cycles.
- T_LAVADO  16  wash duration, in cycles.
- T_ENJUAGUE  8  rinse duration, in cycles.
- T_CENTRIFUGADO  6  spin duration, in cycles.
- T_SECADO  12  dry duration, in cycles.

Function
REQ-003 SHALL sample each command input into a 3-bit history register every cycle; a command is detected when its history equals 1,0,1 (oldest to newest).
REQ-004 SHALL accept a detected command only in IDLE and only when exactly one command line matches; simultaneous matches and single pulses SHALL be ignored.
REQ-005 SHALL leave IDLE on the clock edge after the edge that captured the second high sample (1-cycle acceptance latency).
REQ-006 SHALL implement states IDLE, LLENADO, LAVAR, ENJUAGAR, CENTRIFUGAR, SECAR, FIN.
REQ-007 SHALL sequence the SECADO command as SECAR, then FIN.
REQ-008 SHALL sequence the LAVADO command as LLENADO, LAVAR, ENJUAGAR, CENTRIFUGAR, then FIN.
REQ-009 SHALL sequence the LAVADO_PESADO command as LLENADO, LAVAR for 2*T_LAVADO, ENJUAGAR twice (2*T_ENJUAGUE, two-pass counter), CENTRIFUGAR, SECAR, then FIN.
REQ-010 SHALL hold each stage for exactly its parameter in cycles, using a down-counter loaded on stage entry and advancing when the counter reaches 1.
REQ-011 SHALL decode outputs from registered state: VALVULA_AGUA in LLENADO; MOTOR in LAVAR and ENJUAGAR; MOTOR_RAPIDO in CENTRIFUGAR; RESISTENCIA in SECAR; all actuators low otherwise.
REQ-012 SHALL assert OCUPADO in every state except IDLE; FIN SHALL last 1 cycle, assert FIN_CICLO, then return to IDLE.
REQ-013 SHALL ignore commands received while OCUPADO=1; the history registers keep running.
REQ-014 SHALL set ERROR_PAGO on an INSUFICIENTE high sample while in IDLE, hold it until the next accepted command or reset, and ignore INSUFICIENTE while busy.
REQ-015 SHALL size the timer as ceil(log2(2*max parameter + 1)) bits so it never wraps.

Reset
REQ-016 SHALL, with RESET_N=0, immediately force: state IDLE; timer, pass counter and histories 0; every output 0.
REQ-017 SHALL abort any cycle in progress on reset, with no FIN_CICLO pulse.
REQ-018 SHALL resume normal operation on the first rising clk edge after RESET_N deasserts.

Configuration
REQ-019 SHALL implement the door interlock when macro PUERTA_BLOQUEO_EN is defined: PUERTA_ABIERTA=1 in an active stage freezes the timer, forces all actuators low, and keeps state and OCUPADO; the stage resumes with the remaining count when the door closes; commands in IDLE are ignored while the door is open.
REQ-020 SHALL, without PUERTA_BLOQUEO_EN, ignore PUERTA_ABIERTA entirely; no interlock logic SHALL be synthesized.

Verification
REQ-021 SHALL verify: LAVADO pulses 1,0,1 -> OCUPADO high for 39 cycles (38 stage + 1 FIN); VALVULA_AGUA for 8, MOTOR for 24, MOTOR_RAPIDO for 6; one FIN_CICLO pulse.
REQ-022 SHALL verify: LAVADO_PESADO pattern -> OCUPADO for 75 cycles; MOTOR for 48, RESISTENCIA for 12.
REQ-023 SHALL verify: INSUFICIENTE single pulse -> ERROR_PAGO=1, state stays IDLE; a following SECADO pattern clears ERROR_PAGO, RESISTENCIA is high for 12 cycles.
REQ-024 SHALL verify: SECADO and LAVADO patterns simultaneously, or a lone 1-cycle pulse -> no state change, OCUPADO stays 0.
REQ-025 SHALL verify: RESET_N low mid-LAVAR -> all outputs 0 asynchronously, no FIN_CICLO; next command runs a full cycle.
REQ-026 SHALL verify, with PUERTA_BLOQUEO_EN: door open 5 cycles mid-LAVAR -> MOTOR low for those 5 cycles, LAVAR total lengthened by 5; LAVADO pattern arriving mid-cycle is ignored.

Source files
------------

// File: rtl/ciclo_lavadora.sv
// Washing-machine cycle controller: decodes two-pulse commands and sequences fill/wash/rinse/spin/dry.
// Optional door interlock enabled by defining PUERTA_BLOQUEO_EN.
module ciclo_lavadora #(
    parameter int unsigned T_LLENADO      = 8,
    parameter int unsigned T_LAVADO       = 16,
    parameter int unsigned T_ENJUAGUE     = 8,
    parameter int unsigned T_CENTRIFUGADO = 6,
    parameter int unsigned T_SECADO       = 12
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic SECADO,
    input  logic LAVADO,
    input  logic LAVADO_PESADO,
    input  logic INSUFICIENTE,
    input  logic PUERTA_ABIERTA,
    output logic VALVULA_AGUA,
    output logic MOTOR,
    output logic MOTOR_RAPIDO,
    output logic RESISTENCIA,
    output logic OCUPADO,
    output logic FIN_CICLO,
    output logic ERROR_PAGO
);

    localparam int unsigned MaxA = (T_LLENADO > T_LAVADO) ? T_LLENADO : T_LAVADO;
    localparam int unsigned MaxB = (T_ENJUAGUE > T_CENTRIFUGADO) ? T_ENJUAGUE : T_CENTRIFUGADO;
    localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned TMax = (MaxC > T_SECADO) ? MaxC : T_SECADO;
    localparam int unsigned TW   = $clog2(2 * TMax + 1);

    typedef enum logic [2:0] {
        StIdle, StLlenado, StLavar, StEnjuagar, StCentrifugar, StSecar, StFin
    } state_e;

    typedef enum logic [1:0] {ModoSecado, ModoLavado, ModoPesado} modo_e;

    state_e          state_q, state_d;
    modo_e           modo_q, modo_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pasada_q, pasada_d;
    logic            error_q, error_d;
    logic [2:0]      hist_sec_q, hist_lav_q, hist_pes_q;
    logic            det_s, det_l, det_p, det_uno;
    logic            puerta_hold, puerta_cmd_bloq;

`ifdef PUERTA_BLOQUEO_EN
    assign puerta_hold     = PUERTA_ABIERTA && (state_q inside {StLlenado, StLavar, StEnjuagar,
                                                                StCentrifugar, StSecar});
    assign puerta_cmd_bloq = PUERTA_ABIERTA;
`else
    logic unused_puerta;
    assign unused_puerta   = PUERTA_ABIERTA;
    assign puerta_hold     = 1'b0;
    assign puerta_cmd_bloq = 1'b0;
`endif

    // History holds oldest sample in bit 2, newest in bit 0
    assign det_s   = (hist_sec_q == 3'b101);
    assign det_l   = (hist_lav_q == 3'b101);
    assign det_p   = (hist_pes_q == 3'b101);
    assign det_uno = (det_s ^ det_l ^ det_p) && !(det_s && det_l && det_p);

    always_comb begin
        state_d  = state_q;
        modo_d   = modo_q;
        timer_d  = timer_q;
        pasada_d = pasada_q;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (det_uno && !puerta_cmd_bloq) begin
                    error_d  = 1'b0;
                    pasada_d = 1'b0;
                    if (det_s) begin
                        modo_d  = ModoSecado;
                        state_d = StSecar;
                        timer_d = TW'(T_SECADO);
                    end else begin
                        modo_d  = det_l ? ModoLavado : ModoPesado;
                        state_d = StLlenado;
                        timer_d = TW'(T_LLENADO);
                    end
                end else if (INSUFICIENTE) begin
                    error_d = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
                timer_d = '0;
            end
            default: begin
                if (!puerta_hold) begin
                    if (timer_q != TW'(1)) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        unique case (state_q)
                            StLlenado: begin
                                state_d = StLavar;
                                timer_d = (modo_q == ModoPesado) ? TW'(2 * T_LAVADO)
                                                                 : TW'(T_LAVADO);
                            end
                            StLavar: begin
                                state_d = StEnjuagar;
                                timer_d = TW'(T_ENJUAGUE);
                            end
                            StEnjuagar: begin
                                timer_d = TW'(T_ENJUAGUE);
                                // Heavy wash rinses a second pass before spinning
                                if (modo_q == ModoPesado && !pasada_q) begin
                                    pasada_d = 1'b1;
                                end else begin
                                    state_d = StCentrifugar;
                                    timer_d = TW'(T_CENTRIFUGADO);
                                end
                            end
                            StCentrifugar: begin
                                if (modo_q == ModoPesado) begin
                                    state_d = StSecar;
                                    timer_d = TW'(T_SECADO);
                                end else begin
                                    state_d = StFin;
                                    timer_d = '0;
                                end
                            end
                            default: begin
                                state_d = StFin;
                                timer_d = '0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            modo_q     <= ModoSecado;
            timer_q    <= '0;
            pasada_q   <= 1'b0;
            error_q    <= 1'b0;
            hist_sec_q <= '0;
            hist_lav_q <= '0;
            hist_pes_q <= '0;
        end else begin
            state_q    <= state_d;
            modo_q     <= modo_d;
            timer_q    <= timer_d;
            pasada_q   <= pasada_d;
            error_q    <= error_d;
            hist_sec_q <= {hist_sec_q[1:0], SECADO};
            hist_lav_q <= {hist_lav_q[1:0], LAVADO};
            hist_pes_q <= {hist_pes_q[1:0], LAVADO_PESADO};
        end
    end

    assign VALVULA_AGUA = (state_q == StLlenado) && !puerta_hold;
    assign MOTOR        = (state_q inside {StLavar, StEnjuagar}) && !puerta_hold;
    assign MOTOR_RAPIDO = (state_q == StCentrifugar) && !puerta_hold;
    assign RESISTENCIA  = (state_q == StSecar) && !puerta_hold;
    assign OCUPADO      = (state_q != StIdle);
    assign FIN_CICLO    = (state_q == StFin);
    assign ERROR_PAGO   = error_q;

endmodule

// File: tb/tb_ciclo_lavadora.sv
// Scoreboard bench for ciclo_lavadora: expected per-cycle actuator counts are queued by the
// stimulus and compared by a monitor on each FIN_CICLO pulse.
module tb_ciclo_lavadora;

    logic clk = 1'b0;
    logic RESET_N, SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE, PUERTA_ABIERTA;
    logic VALVULA_AGUA, MOTOR, MOTOR_RAPIDO, RESISTENCIA, OCUPADO, FIN_CICLO, ERROR_PAGO;

    always #5 clk = ~clk;

    ciclo_lavadora dut (
        .clk            (clk),
        .RESET_N        (RESET_N),
        .SECADO         (SECADO),
        .LAVADO         (LAVADO),
        .LAVADO_PESADO  (LAVADO_PESADO),
        .INSUFICIENTE   (INSUFICIENTE),
        .PUERTA_ABIERTA (PUERTA_ABIERTA),
        .VALVULA_AGUA   (VALVULA_AGUA),
        .MOTOR          (MOTOR),
        .MOTOR_RAPIDO   (MOTOR_RAPIDO),
        .RESISTENCIA    (RESISTENCIA),
        .OCUPADO        (OCUPADO),
        .FIN_CICLO      (FIN_CICLO),
        .ERROR_PAGO     (ERROR_PAGO)
    );

    typedef struct {
        int ocup;
        int valv;
        int motor;
        int rapido;
        int resist;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int fin_count = 0;
    int fin_expected = 0;
    int a_ocup, a_valv, a_motor, a_rap, a_res;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int outs();
        return int'({VALVULA_AGUA, MOTOR, MOTOR_RAPIDO, RESISTENCIA, OCUPADO, FIN_CICLO,
                     ERROR_PAGO});
    endfunction

    // Monitor: accumulate actuator-high cycles, compare against scoreboard at FIN_CICLO
    always @(negedge clk) begin
        if (!RESET_N) begin
            a_ocup = 0; a_valv = 0; a_motor = 0; a_rap = 0; a_res = 0;
        end else begin
            if (OCUPADO)      a_ocup++;
            if (VALVULA_AGUA) a_valv++;
            if (MOTOR)        a_motor++;
            if (MOTOR_RAPIDO) a_rap++;
            if (RESISTENCIA)  a_res++;
            if (FIN_CICLO) begin
                fin_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_fin", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ocupado_cycles", a_ocup, e.ocup);
                    chk("valvula_cycles", a_valv, e.valv);
                    chk("motor_cycles", a_motor, e.motor);
                    chk("rapido_cycles", a_rap, e.rapido);
                    chk("resist_cycles", a_res, e.resist);
                end
                a_ocup = 0; a_valv = 0; a_motor = 0; a_rap = 0; a_res = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse3(input logic s, input logic l, input logic p);
        SECADO = s; LAVADO = l; LAVADO_PESADO = p;
        tick();
        SECADO = 0; LAVADO = 0; LAVADO_PESADO = 0;
        tick();
        SECADO = s; LAVADO = l; LAVADO_PESADO = p;
        tick();
        SECADO = 0; LAVADO = 0; LAVADO_PESADO = 0;
    endtask

    task automatic expect_cycle(input int o, input int v, input int m, input int r, input int h);
        exp_t e;
        e.ocup = o; e.valv = v; e.motor = m; e.rapido = r; e.resist = h;
        exp_q.push_back(e);
        fin_expected++;
    endtask

    initial begin
        int seen;
        int fin_before;
        RESET_N = 0; SECADO = 0; LAVADO = 0; LAVADO_PESADO = 0;
        INSUFICIENTE = 0; PUERTA_ABIERTA = 0;
        #3;
        chk("reset_outputs", outs(), 0);
        tick(2);
        RESET_N = 1;
        tick();
        chk("idle_outputs", outs(), 0);

        // Normal wash, with a drying command issued while busy (must be ignored)
        expect_cycle(39, 8, 24, 6, 0);
        pulse3(0, 1, 0);
        tick();
        chk("lavado_start_valvula", int'(VALVULA_AGUA), 1);
        tick(20);
        pulse3(1, 0, 0);
        tick(40);
        chk("lavado_done_idle", int'(OCUPADO), 0);

        // Heavy wash
        expect_cycle(75, 8, 48, 6, 12);
        pulse3(0, 0, 1);
        tick(90);

        // Payment error, then drying clears it
        INSUFICIENTE = 1;
        tick();
        INSUFICIENTE = 0;
        chk("error_pago_set", int'(ERROR_PAGO), 1);
        chk("error_stays_idle", int'(OCUPADO), 0);
        expect_cycle(13, 0, 0, 0, 12);
        pulse3(1, 0, 0);
        tick();
        chk("error_pago_cleared", int'(ERROR_PAGO), 0);
        chk("secado_resist_on", int'(RESISTENCIA), 1);
        tick(25);

        // Simultaneous commands and a lone pulse are both ignored
        pulse3(1, 1, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OCUPADO) seen++;
        end
        chk("simultaneous_ignored", seen, 0);
        LAVADO = 1;
        tick();
        LAVADO = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OCUPADO) seen++;
        end
        chk("lone_pulse_ignored", seen, 0);

        // Reset mid-LAVAR aborts without FIN_CICLO
        pulse3(0, 1, 0);
        tick(15);
        chk("mid_lavar_motor", int'(MOTOR), 1);
        fin_before = fin_count;
        #2 RESET_N = 0;
        #1 chk("async_reset_outputs", outs(), 0);
        tick(2);
        chk("no_fin_on_abort", fin_count, fin_before);
        RESET_N = 1;
        tick();
        expect_cycle(39, 8, 24, 6, 0);
        pulse3(0, 1, 0);
        tick(45);

`ifdef PUERTA_BLOQUEO_EN
        // Door open 5 cycles mid-LAVAR stretches the cycle and silences the motor
        expect_cycle(44, 8, 24, 6, 0);
        pulse3(0, 1, 0);
        tick(15);
        PUERTA_ABIERTA = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (MOTOR) seen++;
            tick();
        end
        PUERTA_ABIERTA = 0;
        chk("door_motor_off", seen, 0);
        pulse3(0, 1, 0);
        tick(40);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("fin_count", fin_count, fin_expected);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
